// File: rtl/round_robin_arbiter_weighted_slices_pkg.sv
// Shared defaults and FSM encoding for the weighted-slice round-robin arbiter.
package round_robin_arbiter_weighted_slices_pkg;
  localparam int DEF_N       = 4;
  localparam int DEF_SLICE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/round_robin_arbiter_weighted_slices_rr_next_picker.sv
// Combinational round-robin search: first requester after ptr, wrapping, ptr itself last.
module rr_next_picker
  import round_robin_arbiter_weighted_slices_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             excl_owner,
  output logic [IDX_W-1:0] win,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    // k == N lands back on ptr, which is skipped when the owner released early
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand] && !(excl_owner && (k == N))) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter_weighted_slices.sv
// Round-robin arbiter granting each winner a per-requester time slice of SLICE cycles.
module round_robin_arbiter_weighted_slices
  import round_robin_arbiter_weighted_slices_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         REQ,
  input  logic [N*SLICE_W-1:0] SLICE,
  output logic [N-1:0]         GNT,
  output logic [IDX_W-1:0]     GNT_ID,
  output logic                 GNT_VALID,
  output logic [SLICE_W-1:0]   SLICE_LEFT
);

  arb_state_t         state_p0, state_p1;
  logic [IDX_W-1:0]   ptr_p0, ptr_p1;
  logic [N-1:0]       gnt_p0, gnt_p1;
  logic [IDX_W-1:0]   id_p0, id_p1;
  logic               vld_p0, vld_p1;
  logic [SLICE_W-1:0] left_p0, left_p1;

  logic               arb;
  logic               excl;
  logic [IDX_W-1:0]   win;
  logic               found;

  // Remaining cycles after the grant cycle; a zero field still buys one cycle.
  function automatic logic [SLICE_W-1:0] first_slice_left(
    input logic [N*SLICE_W-1:0] s,
    input logic [IDX_W-1:0]     w
  );
    logic [SLICE_W-1:0] f;
    f = s[int'(w)*SLICE_W +: SLICE_W];
    return (f == '0) ? '0 : f - SLICE_W'(1);
  endfunction

  rr_next_picker #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (REQ),
    .ptr        (ptr_p1),
    .excl_owner (excl),
    .win        (win),
    .found      (found)
  );

  // p0: next-state decision from sampled REQ and current ownership
  always_comb begin
    state_p0 = state_p1;
    ptr_p0   = ptr_p1;
    gnt_p0   = gnt_p1;
    id_p0    = id_p1;
    vld_p0   = vld_p1;
    left_p0  = left_p1;
    arb      = 1'b0;
    excl     = 1'b0;

    case (state_p1)
      IDLE: arb = |REQ;
      OWN: begin
        // ptr tracks the owner while in OWN, so REQ[ptr] is the owner's request
        if (!REQ[ptr_p1]) begin
          arb  = 1'b1;
          excl = 1'b1;
        end else if (left_p1 == '0) begin
          arb = 1'b1;
        end else begin
          left_p0 = left_p1 - SLICE_W'(1);
        end
      end
      default: arb = 1'b0;
    endcase

    if (arb) begin
      if (found) begin
        state_p0    = OWN;
        ptr_p0      = win;
        gnt_p0      = '0;
        gnt_p0[win] = 1'b1;
        id_p0       = win;
        vld_p0      = 1'b1;
        left_p0     = first_slice_left(SLICE, win);
      end else begin
        state_p0 = IDLE;
        gnt_p0   = '0;
        id_p0    = '0;
        vld_p0   = 1'b0;
        left_p0  = '0;
      end
    end
  end

  // p1: registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
      ptr_p1   <= IDX_W'(N - 1);
      gnt_p1   <= '0;
      id_p1    <= '0;
      vld_p1   <= 1'b0;
      left_p1  <= '0;
    end else begin
      state_p1 <= state_p0;
      ptr_p1   <= ptr_p0;
      gnt_p1   <= gnt_p0;
      id_p1    <= id_p0;
      vld_p1   <= vld_p0;
      left_p1  <= left_p0;
    end
  end

  assign GNT        = gnt_p1;
  assign GNT_ID     = id_p1;
  assign GNT_VALID  = vld_p1;
  assign SLICE_LEFT = left_p1;

endmodule

// File: doc/round_robin_arbiter_weighted_slices.md
ROUND_ROBIN_ARBITER_WEIGHTED_SLICES -- requirements
Module: round_robin_arbiter_weighted_slices

Interface
REQ-001 Parameter N, default 4, number of requesters (N >= 2).
REQ-002 Parameter SLICE_W, default 4, width of each per-requester slice-length field.
REQ-003 Parameter IDX_W, default $clog2(N), width of the grant index.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port REQ  input  N  request vector, bit i = requester i.
REQ-007 Port SLICE  input  N*SLICE_W  slice length in cycles; field i is bits [i*SLICE_W +: SLICE_W].
REQ-008 Port GNT  output  N  registered one-hot grant, or all-zero when idle.
REQ-009 Port GNT_ID  output  IDX_W  registered index of the current owner; 0 when idle.
REQ-010 Port GNT_VALID  output  1  registered; high iff GNT is non-zero.
REQ-011 Port SLICE_LEFT  output  SLICE_W  registered cycles remaining after the current one; 0 when idle.

Function
REQ-012 FSM has two states: IDLE (no owner) and OWN (exactly one GNT bit high).
REQ-013 Pointer PTR holds the index of the last owner; search order is PTR+1, PTR+2, ... wrapping modulo N, ending with PTR itself.
REQ-014 In IDLE at a rising edge with REQ != 0: first requesting index in search order becomes owner; GNT, GNT_ID and GNT_VALID update at that edge; state -> OWN; PTR <= winner.
REQ-015 Grant latency: REQ asserted before edge k produces GNT at edge k (one registered stage, no combinational REQ->GNT path).
REQ-016 On grant, SLICE_LEFT <= eff_slice(winner) - 1; eff_slice = SLICE field, except that a 0 field is treated as 1.
REQ-017 SLICE is sampled only at the grant edge; changes mid-slice do not affect the current slice.
REQ-018 In OWN with REQ[owner]=1 and SLICE_LEFT > 0: grant held; SLICE_LEFT decrements by 1.
REQ-019 In OWN with REQ[owner]=1 and SLICE_LEFT = 0 (slice expired): re-arbitrate per REQ-013/014 at that edge, owner included last, so a sole requester is re-granted a fresh slice with no gap.
REQ-020 In OWN with REQ[owner]=0 (early release): re-arbitrate at that edge among the other requesters only; if none, state -> IDLE with GNT=0, GNT_ID=0, SLICE_LEFT=0.
REQ-021 Handover between owners is back-to-back: no idle cycle and never two GNT bits high.
REQ-022 Early release takes priority over slice expiry when both occur at the same edge.
REQ-023 A requester holding REQ continuously is granted within (N-1)*(2^SLICE_W) cycles (starvation bound).
REQ-024 Requests that rise and fall between edges are ignored; only values sampled at the edge count.

Reset
REQ-025 With rst=1 at a rising edge: state=IDLE, GNT=0, GNT_ID=0, GNT_VALID=0, SLICE_LEFT=0, PTR=N-1 (requester 0 has first priority).
REQ-026 Reset asserted mid-slice drops the grant at that edge; reset overrides all other conditions.
REQ-027 Arbitration resumes at the first edge with rst=0.

Structure
REQ-028 A shared package holds the default N and SLICE_W values and the FSM state encoding (IDLE, OWN).
REQ-029 One sub-module, rr_next_picker, is combinational: (REQ, PTR, exclude-owner flag) -> winner index and found flag.
REQ-030 The top module holds the FSM, PTR, slice counter and registered outputs.

Verification (N=4, SLICE_W=4)
REQ-031 Reset, then REQ=4'b0001, all SLICE=3 -> GNT=0001 at the first edge, held 3 cycles, then re-granted 0001 with SLICE_LEFT reloaded to 2.
REQ-032 REQ=4'b1010 held, SLICE={1:2, 3:4} -> GNT=0010 for 2 cycles, then 1000 for 4 cycles, repeating with no gap.
REQ-033 REQ=4'b1111 held, all SLICE=1 -> GNT rotates 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-034 Owner 2 drops REQ after 1 of 5 slice cycles while REQ[0]=1 -> GNT=0001 at that edge; PTR=0.
REQ-035 SLICE field = 0 -> 1-cycle slice; rst pulsed mid-slice -> GNT=0, SLICE_LEFT=0 at that edge; next grant goes to the lowest requesting index.
